regfile_mp_sb: RTL

Parametrised multi-port integer register file with hardwired-zero entry 0, same-cycle write-to-read forwarding, and an integrated busy-bit scoreboard for in-flight writebacks. Includes a sequential clear engine that zeroes the array after reset or on request. Sits between decode (read/issue) and writeback in the pipeline. Successor to the single-write/dual-read file.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_scoreboard.sv | 49 ++++
 rtl/regfile_mp_sb.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [DATA_W_DEF-1:0] DATA_ZERO = '0;

    localparam logic WE_ON = 1'b1;
    localparam logic RE_ON = 1'b1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    output logic [2**ADDR_W-1:0]     busy
);

    logic [2**ADDR_W-1:0] busy_q;
    logic [2**ADDR_W-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr) begin
            busy_d = '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (we[k] == WE_ON) begin
                    busy_d[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            // Applied after the clears: a newer producer outranks the retiring one.
            if (iss_en && iss_addr != '0) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with zero entry, write-to-read forwarding,
// busy scoreboard and a sequential clear sweep after reset or on request.
//
//   state    | meaning
//   ST_CLEAR | sweeping entries 1..DEPTH-1 to zero, one per cycle; not ready
//   ST_IDLE  | array valid; reads, writes and issues accepted
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter bit FWD_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    output logic                     ready,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] ZERO_W    = DATA_W'(DATA_ZERO);

    rf_state_e         state_q;
    rf_state_e         state_d;
    logic [ADDR_W-1:0] clr_idx_q;
    logic [ADDR_W-1:0] clr_idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              live;
    logic [NUM_WR-1:0] we_eff;
    logic [DEPTH-1:0]  busy;
    logic [ADDR_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_v;
    logic              rd_hit;

    assign ready = (state_q == ST_IDLE);
    assign live  = ready & ~rst;

    // Writes to entry 0 are dropped here so neither the array nor the scoreboard sees them.
    always_comb begin
        we_eff = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            we_eff[k] = live & (we[k] == WE_ON) & (waddr[k*ADDR_W +: ADDR_W] != '0);
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + IDX_FIRST;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = IDX_FIRST;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = IDX_FIRST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= IDX_FIRST;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (state_q == ST_CLEAR && !rst) begin
            mem_d[clr_idx_q] = ZERO_W;
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (we_eff[k]) begin
                mem_d[waddr[k*ADDR_W +: ADDR_W]] = wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rdata  = '0;
        rbusy  = '0;
        rd_a   = '0;
        rd_v   = '0;
        rd_hit = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_a   = raddr[i*ADDR_W +: ADDR_W];
            rd_v   = mem_q[rd_a];
            rd_hit = 1'b0;
            if (FWD_EN) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (we_eff[k] && waddr[k*ADDR_W +: ADDR_W] == rd_a) begin
                        rd_v   = wdata[k*DATA_W +: DATA_W];
                        rd_hit = 1'b1;
                    end
                end
            end
            if (live && re[i] == RE_ON && rd_a != '0) begin
                rdata[i*DATA_W +: DATA_W] = rd_v;
                rbusy[i]                  = busy[rd_a] & ~rd_hit;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .clr      (ready & clr_req),
        .iss_en   (iss_en & live),
        .iss_addr (iss_addr),
        .we       (we_eff),
        .waddr    (waddr),
        .busy     (busy)
    );

endmodule
